// File: rtl/alu_mdu.sv
// alu_mdu: EX-stage ALU with registered results and an iterative
// multiply/divide unit that owns the architectural HI/LO registers.
//
// Optional feature macro: ALU_MDU_OVF_EN adds the `overflow` output
// (signed ADD/SUB overflow and DIV MIN/-1), registered alongside `result`.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operation request
//   in_ready   unit can accept (state is IDLE)
//   a, b       operands (a[SHW-1:0] is the shift amount for shifts)
//   oper       operation code
//   out_valid  one-cycle pulse: result/hi/lo are valid
//   result     registered result (lo for multiply/divide)
//   hi, lo     HI/LO registers (product halves, or remainder/quotient)
//   busy       multiply/divide in progress
//   overflow   (ALU_MDU_OVF_EN only) signed overflow flag
//
// Multiply/divide timing: the accept edge latches operand magnitudes, WIDTH
// ITER cycles each perform one shift-add or restoring-subtract step, and one
// FIX cycle applies sign correction and writes HI/LO. in_ready is low for
// those WIDTH+1 cycles; out_valid is registered at the FIX edge, so it is
// seen in the same cycle that in_ready returns high.
module alu_mdu #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       oper,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
`ifdef ALU_MDU_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_SLT   = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_OR    = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLTU  = 4'd8;
  localparam logic [3:0] OP_XOR   = 4'd9;
  localparam logic [3:0] OP_NOR   = 4'd10;
  localparam logic [3:0] OP_MULT  = 4'd11;
  localparam logic [3:0] OP_MULTU = 4'd12;
  localparam logic [3:0] OP_DIV   = 4'd13;
  localparam logic [3:0] OP_DIVU  = 4'd14;

  typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, FIX = 2'd2} state_t;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + 1'b1;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return ~x + 1'b1;
  endfunction

  function automatic logic [WIDTH-1:0] alu_fn(input logic [3:0] op,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    logic [SHW-1:0] sh;
    sh = x[SHW-1:0];
    case (op)
      OP_ADD:  alu_fn = x + y;
      OP_SUB:  alu_fn = x - y;
      OP_SLT:  alu_fn = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      OP_AND:  alu_fn = x & y;
      OP_OR:   alu_fn = x | y;
      OP_SLL:  alu_fn = y << sh;
      OP_SRL:  alu_fn = y >> sh;
      OP_SRA:  alu_fn = $signed(y) >>> sh;
      OP_SLTU: alu_fn = {{(WIDTH-1){1'b0}}, (x < y)};
      OP_XOR:  alu_fn = x ^ y;
      OP_NOR:  alu_fn = ~(x | y);
      default: alu_fn = '0;
    endcase
  endfunction

`ifdef ALU_MDU_OVF_EN
  function automatic logic ovf_fn(input logic [3:0] op,
                                  input logic [WIDTH-1:0] x,
                                  input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] d;
    s = x + y;
    d = x - y;
    case (op)
      OP_ADD:  ovf_fn = (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
      OP_SUB:  ovf_fn = (x[WIDTH-1] != y[WIDTH-1]) && (d[WIDTH-1] != x[WIDTH-1]);
      default: ovf_fn = 1'b0;
    endcase
  endfunction
`endif

  state_t           state;
  logic [SHW-1:0]   cnt_p0;
  logic             div_p0;
  logic             res_neg_p0;
  logic             rem_neg_p0;
  logic [WIDTH-1:0] opd_p0;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc_p0;   // product upper half or partial remainder
  logic [WIDTH-1:0] low_p0;   // multiplier/product low or dividend/quotient

  logic             accept;
  logic             is_md;
  logic             is_div;
  logic             is_sgn;
  logic             div_zero;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  assign is_md    = (oper == OP_MULT) || (oper == OP_MULTU) ||
                    (oper == OP_DIV)  || (oper == OP_DIVU);
  assign is_div   = (oper == OP_DIV) || (oper == OP_DIVU);
  assign is_sgn   = (oper == OP_MULT) || (oper == OP_DIV);
  assign div_zero = is_div && (b == '0);
  assign a_neg    = is_sgn && a[WIDTH-1];
  assign b_neg    = is_sgn && b[WIDTH-1];
  assign a_mag    = a_neg ? neg_w(a) : a;
  assign b_mag    = b_neg ? neg_w(b) : b;

  // One shift-add multiply step: add multiplicand when the multiplier LSB
  // is set, then shift the {acc,low} pair right by one.
  logic [WIDTH:0] msum;
  assign msum = {1'b0, acc_p0} + (low_p0[0] ? {1'b0, opd_p0} : '0);

  // One restoring-divide step: bring in the next dividend bit, subtract the
  // divisor if it fits; the quotient bit shifts in where the dividend left.
  logic [WIDTH:0]   rem_sh;
  logic             dge;
  logic [WIDTH-1:0] dsub;
  assign rem_sh = {acc_p0, low_p0[WIDTH-1]};
  assign dge    = rem_sh >= {1'b0, opd_p0};
  assign dsub   = rem_sh[WIDTH-1:0] - opd_p0;

  logic [WIDTH-1:0] step_acc;
  logic [WIDTH-1:0] step_low;
  assign step_acc = div_p0 ? (dge ? dsub : rem_sh[WIDTH-1:0]) : msum[WIDTH:1];
  assign step_low = div_p0 ? {low_p0[WIDTH-2:0], dge} : {msum[0], low_p0[WIDTH-1:1]};

  // Sign correction: product/quotient follow sign(a)^sign(b), remainder
  // follows the dividend. MIN/-1 wraps back to MIN with remainder 0.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;
  assign prod_fix = res_neg_p0 ? neg_2w({acc_p0, low_p0}) : {acc_p0, low_p0};
  assign fix_hi   = div_p0 ? (rem_neg_p0 ? neg_w(acc_p0) : acc_p0)
                           : prod_fix[2*WIDTH-1:WIDTH];
  assign fix_lo   = div_p0 ? (res_neg_p0 ? neg_w(low_p0) : low_p0)
                           : prod_fix[WIDTH-1:0];

`ifdef ALU_MDU_OVF_EN
  logic ovf_p0;
  logic min_neg1;
  assign min_neg1 = (oper == OP_DIV) && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (&b);
`endif

  // Stage p0: control FSM and architectural outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      result     <= '0;
      hi         <= '0;
      lo         <= '0;
      cnt_p0     <= '0;
      div_p0     <= 1'b0;
      res_neg_p0 <= 1'b0;
      rem_neg_p0 <= 1'b0;
`ifdef ALU_MDU_OVF_EN
      overflow   <= 1'b0;
      ovf_p0     <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (div_zero) begin
              result    <= '1;
              lo        <= '1;
              hi        <= a;
              out_valid <= 1'b1;
`ifdef ALU_MDU_OVF_EN
              overflow  <= 1'b0;
`endif
            end else if (is_md) begin
              state      <= ITER;
              cnt_p0     <= SHW'(WIDTH-1);
              div_p0     <= is_div;
              res_neg_p0 <= a_neg ^ b_neg;
              rem_neg_p0 <= a_neg;
`ifdef ALU_MDU_OVF_EN
              ovf_p0     <= min_neg1;
`endif
            end else begin
              result    <= alu_fn(oper, a, b);
              out_valid <= 1'b1;
`ifdef ALU_MDU_OVF_EN
              overflow  <= ovf_fn(oper, a, b);
`endif
            end
          end
        end
        ITER: begin
          cnt_p0 <= cnt_p0 - 1'b1;
          if (cnt_p0 == '0) state <= FIX;
        end
        FIX: begin
          hi        <= fix_hi;
          lo        <= fix_lo;
          result    <= fix_lo;
          out_valid <= 1'b1;
`ifdef ALU_MDU_OVF_EN
          overflow  <= ovf_p0;
`endif
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p0: iterative datapath (no reset; loaded at every accept)
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      if (accept && is_md) begin
        opd_p0 <= b_mag;
        low_p0 <= a_mag;
        acc_p0 <= '0;
      end
    end else if (state == ITER) begin
      acc_p0 <= step_acc;
      low_p0 <= step_low;
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
`timescale 1ns/1ps
module tb_alu_mdu;
`ifdef ALU_MDU_OVF_EN
  localparam int W = 8;
`else
  localparam int W = 32;
`endif
  localparam logic [W-1:0] ONES = '1;
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   oper = 4'd0;
  logic         out_valid;
  logic [W-1:0] result;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
`ifdef ALU_MDU_OVF_EN
  logic         overflow;
`endif

  alu_mdu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .oper(oper), .out_valid(out_valid), .result(result),
    .hi(hi), .lo(lo), .busy(busy)
`ifdef ALU_MDU_OVF_EN
    , .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected response. lat = cycles from the issuing negedge to the negedge
  // at which out_valid is seen: 1 for single-cycle ops; for multiply/divide
  // out_valid is registered WIDTH+1 edges after the accept edge, i.e. seen
  // at W+2, together with in_ready returning high.
  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         ovf;
    int           acc_cyc;
    int           lat;
  } exp_t;

  exp_t sbq[$];
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: plain wide arithmetic on the spec's rules.
  function automatic void model(input logic [3:0] op, input logic [W-1:0] x,
                                input logic [W-1:0] y, output exp_t e);
    longint          sx, sy, r64, lim;
    longint unsigned ux, uy, p;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    ux  = longint'(x);
    uy  = longint'(y);
    lim = longint'(1) << (W - 1);
    e.hi = m_hi; e.lo = m_lo; e.ovf = 1'b0; e.lat = 1; e.res = '0;
    e.acc_cyc = 0;
    case (op)
      4'd0: begin r64 = sx + sy; e.res = x + y; e.ovf = (r64 >= lim) || (r64 < -lim); end
      4'd1: begin r64 = sx - sy; e.res = x - y; e.ovf = (r64 >= lim) || (r64 < -lim); end
      4'd2: e.res = (sx < sy) ? W'(1) : W'(0);
      4'd3: e.res = x & y;
      4'd4: e.res = x | y;
      4'd5: e.res = W'(uy << (ux % W));
      4'd6: e.res = W'(uy >> (ux % W));
      4'd7: e.res = W'(sy >>> (ux % W));
      4'd8: e.res = (ux < uy) ? W'(1) : W'(0);
      4'd9: e.res = x ^ y;
      4'd10: e.res = ~(x | y);
      4'd11, 4'd12: begin
        p = (op == 4'd11) ? longint'(sx * sy) : ux * uy;
        e.lo = W'(p); e.hi = W'(p >> W); e.res = e.lo; e.lat = W + 2;
      end
      4'd13, 4'd14: begin
        if (y == '0) begin
          e.lo = ONES; e.hi = x; e.res = ONES; e.lat = 1;
        end else if (op == 4'd13 && x == MINV && y == ONES) begin
          e.lo = MINV; e.hi = '0; e.res = MINV; e.ovf = 1'b1; e.lat = W + 2;
        end else begin
          if (op == 4'd13) begin e.lo = W'(sx / sy); e.hi = W'(sx % sy); end
          else             begin e.lo = W'(ux / uy); e.hi = W'(ux % uy); end
          e.res = e.lo; e.lat = W + 2;
        end
      end
      default: e.res = '0;
    endcase
    m_hi = e.hi;
    m_lo = e.lo;
  endfunction

  // Monitor: every out_valid pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid) begin
      if (sbq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_out_valid: got 1 want 0 (cyc %0d)", cyc);
      end else begin
        e = sbq.pop_front();
        chk("result", result, e.res);
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
        chk("latency", cyc - e.acc_cyc, e.lat);
`ifdef ALU_MDU_OVF_EN
        chk("overflow", overflow, e.ovf);
`endif
      end
    end
  end

  // Called and returning at a negedge; holds in_valid until accepted.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int   waited = 0;
    in_valid = 1'b1; oper = op; a = x; b = y;
    while (!in_ready && waited < 4 * W) begin @(negedge clk); waited++; end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL issue_timeout: in_ready=0 after %0d cycles, want 1", waited);
    end else begin
      model(op, x, y, e);
      e.acc_cyc = cyc;
      sbq.push_back(e);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sbq.size() != 0 && t < 8 * W) begin @(negedge clk); t++; end
    if (sbq.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", sbq.size());
      sbq.delete();
    end
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return W'(1);
      2: return ONES;
      3: return MINV;
      4: return MAXV;
      default: return W'($urandom());
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-up reset, two edges
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_result", result, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back single-cycle ops
    issue(4'd0, ONES, W'(1));
    issue(4'd7, W'(4), MINV);
    issue(4'd8, W'(1), ONES);
    issue(4'd10, '0, '0);
    drain();

    // Signed MULT with a request held while busy
    issue(4'd11, W'(-3), W'(7));
    in_valid = 1'b1; oper = 4'd0; a = W'(5); b = W'(6);
    for (int i = 0; i < W + 1; i++) begin
      chk("busy_in_ready", in_ready, 0);
      chk("busy_flag", busy, 1);
      @(negedge clk);
    end
    chk("mul_done_in_ready", in_ready, 1);
    chk("mul_done_out_valid", out_valid, 1);
    issue(4'd0, W'(5), W'(6));
    drain();

    // Divide cases and divide by zero
    issue(4'd13, W'(-7), W'(2));
    issue(4'd14, W'(100), W'(7));
    issue(4'd13, MINV, ONES);
    issue(4'd14, W'(5), '0);
    issue(4'd3, ONES, W'(3));
    drain();

    // Unsigned extremes and signed ADD/SUB overflow
    issue(4'd12, ONES, ONES);
    issue(4'd0, MAXV, W'(1));
    issue(4'd1, MINV, W'(1));
    issue(4'd15, ONES, ONES);
    drain();

    // Reset during multiply cycle 10, with HI/LO previously nonzero
    issue(4'd12, ONES, W'(3));
    drain();
    in_valid = 1'b1; oper = 4'd11; a = W'(-5); b = W'(9);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    repeat (W + 4) @(negedge clk);
    issue(4'd4, W'(1), W'(2));
    drain();

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      issue(4'($urandom_range(0, 15)), pick(), pick());
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
